// File: rtl/addr_mux.sv
// ---------------------------------------------------------------------------
// addr_mux
//
// Memory address source selector for the RISC datapath. The memory address
// bus is driven combinationally from either the program counter (instruction
// fetch) or the instruction operand field (data access). A registered copy of
// the selected address and select, plus a one-cycle change strobe, are kept
// for downstream pipeline and debug logic.
//
// Parameters:
//   AWIDTH     - address width (default 5, a 32-word memory)
//
// Ports:
//   clk        - system clock, registered outputs update on the rising edge
//   rst_n      - asynchronous active-low reset
//   sel        - source select: 1 = pc_addr, 0 = op_addr
//   hold       - 1 freezes the registered outputs (mem_addr is unaffected)
//   pc_addr    - program counter address
//   op_addr    - operand address from the instruction register
//   mem_addr   - selected address, combinational
//   mem_addr_q - selected address registered one cycle
//   sel_q      - sel registered alongside mem_addr_q
//   addr_chg   - one-cycle strobe: registered address or source changed
// ---------------------------------------------------------------------------
module addr_mux #(
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              hold,
  input  logic [AWIDTH-1:0] pc_addr,
  input  logic [AWIDTH-1:0] op_addr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [AWIDTH-1:0] mem_addr_q,
  output logic              sel_q,
  output logic              addr_chg
);

  // Set when the value about to be captured differs from the one currently
  // held. The select is part of the comparison so that switching source
  // between two equal addresses still counts as a change.
  logic capture_differs;

  // The memory bus follows the inputs with no clock or reset involvement, so
  // the address stays valid even while the registers are held in reset.
  always_comb begin
    mem_addr = sel ? pc_addr : op_addr;
  end

  always_comb begin
    capture_differs = ({sel, mem_addr} != {sel_q, mem_addr_q});
  end

  // Capture register. Reset clears everything immediately; hold freezes the
  // captured address and select and suppresses the strobe, taking priority
  // over any select change arriving in the same cycle. The first capture
  // after reset compares against the cleared values, so capturing address 0
  // from the operand source produces no strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= '0;
      sel_q      <= 1'b0;
      addr_chg   <= 1'b0;
    end else if (hold) begin
      addr_chg   <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr;
      sel_q      <= sel;
      addr_chg   <= capture_differs;
    end
  end

endmodule

// File: tb/tb_addr_mux.sv
// ---------------------------------------------------------------------------
// tb_addr_mux
//
// Directed testbench for addr_mux. Each scenario task drives inputs away from
// the rising edge and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_addr_mux;

  localparam int AWIDTH = 5;

  logic              clk;
  logic              rst_n;
  logic              sel;
  logic              hold;
  logic [AWIDTH-1:0] pc_addr;
  logic [AWIDTH-1:0] op_addr;
  logic [AWIDTH-1:0] mem_addr;
  logic [AWIDTH-1:0] mem_addr_q;
  logic              sel_q;
  logic              addr_chg;

  int checks;
  int passed;

  addr_mux #(.AWIDTH(AWIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel),
    .hold       (hold),
    .pc_addr    (pc_addr),
    .op_addr    (op_addr),
    .mem_addr   (mem_addr),
    .mem_addr_q (mem_addr_q),
    .sel_q      (sel_q),
    .addr_chg   (addr_chg)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle 1 unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0; sel = 1'b0; pc_addr = 5'h0A; op_addr = 5'h14;
    #1;
    checks++; if (mem_addr !== 5'h14) $display("[TB] FAIL reset_mem_addr: got %h expected %h", mem_addr, 5'h14); else passed++;
    checks++; if (mem_addr_q !== 5'h00) $display("[TB] FAIL reset_mem_addr_q: got %h expected %h", mem_addr_q, 5'h00); else passed++;
    checks++; if (sel_q !== 1'b0) $display("[TB] FAIL reset_sel_q: got %b expected %b", sel_q, 1'b0); else passed++;
    checks++; if (addr_chg !== 1'b0) $display("[TB] FAIL reset_addr_chg: got %b expected %b", addr_chg, 1'b0); else passed++;
    tick();
    checks++; if (mem_addr_q !== 5'h00) $display("[TB] FAIL reset_held_mem_addr_q: got %h expected %h", mem_addr_q, 5'h00); else passed++;
    checks++; if (addr_chg !== 1'b0) $display("[TB] FAIL reset_held_addr_chg: got %b expected %b", addr_chg, 1'b0); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_op_select();
    tick();
    checks++; if (mem_addr_q !== 5'h14) $display("[TB] FAIL op_mem_addr_q: got %h expected %h", mem_addr_q, 5'h14); else passed++;
    checks++; if (sel_q !== 1'b0) $display("[TB] FAIL op_sel_q: got %b expected %b", sel_q, 1'b0); else passed++;
    checks++; if (addr_chg !== 1'b1) $display("[TB] FAIL op_addr_chg: got %b expected %b", addr_chg, 1'b1); else passed++;
    tick();
    checks++; if (addr_chg !== 1'b0) $display("[TB] FAIL op_addr_chg_drop: got %b expected %b", addr_chg, 1'b0); else passed++;
  endtask

  task automatic test_sel_switch();
    sel = 1'b1;
    #1;
    checks++; if (mem_addr !== 5'h0A) $display("[TB] FAIL sw_mem_addr: got %h expected %h", mem_addr, 5'h0A); else passed++;
    checks++; if (mem_addr_q !== 5'h14) $display("[TB] FAIL sw_q_before_edge: got %h expected %h", mem_addr_q, 5'h14); else passed++;
    tick();
    checks++; if (mem_addr_q !== 5'h0A) $display("[TB] FAIL sw_mem_addr_q: got %h expected %h", mem_addr_q, 5'h0A); else passed++;
    checks++; if (sel_q !== 1'b1) $display("[TB] FAIL sw_sel_q: got %b expected %b", sel_q, 1'b1); else passed++;
    checks++; if (addr_chg !== 1'b1) $display("[TB] FAIL sw_addr_chg: got %b expected %b", addr_chg, 1'b1); else passed++;
    tick();
    checks++; if (addr_chg !== 1'b0) $display("[TB] FAIL sw_addr_chg_drop: got %b expected %b", addr_chg, 1'b0); else passed++;
  endtask

  task automatic test_full_range();
    sel = 1'b1; pc_addr = 5'h1F; op_addr = 5'h03;
    #1;
    checks++; if (mem_addr !== 5'h1F) $display("[TB] FAIL range_mem_addr_pc: got %h expected %h", mem_addr, 5'h1F); else passed++;
    tick();
    checks++; if (mem_addr_q !== 5'h1F) $display("[TB] FAIL range_q_pc: got %h expected %h", mem_addr_q, 5'h1F); else passed++;
    checks++; if (addr_chg !== 1'b1) $display("[TB] FAIL range_chg_pc: got %b expected %b", addr_chg, 1'b1); else passed++;
    sel = 1'b0;
    #1;
    checks++; if (mem_addr !== 5'h03) $display("[TB] FAIL range_mem_addr_op: got %h expected %h", mem_addr, 5'h03); else passed++;
    tick();
    checks++; if (mem_addr_q !== 5'h03) $display("[TB] FAIL range_q_op: got %h expected %h", mem_addr_q, 5'h03); else passed++;
    checks++; if (sel_q !== 1'b0) $display("[TB] FAIL range_sel_q_op: got %b expected %b", sel_q, 1'b0); else passed++;
    checks++; if (addr_chg !== 1'b1) $display("[TB] FAIL range_chg_op: got %b expected %b", addr_chg, 1'b1); else passed++;
    tick();
    checks++; if (addr_chg !== 1'b0) $display("[TB] FAIL range_chg_drop: got %b expected %b", addr_chg, 1'b0); else passed++;
  endtask

  task automatic test_hold();
    hold = 1'b1; sel = 1'b1; pc_addr = 5'h11; op_addr = 5'h05;
    #1;
    checks++; if (mem_addr !== 5'h11) $display("[TB] FAIL hold_mem_addr_a: got %h expected %h", mem_addr, 5'h11); else passed++;
    tick();
    checks++; if (mem_addr_q !== 5'h03) $display("[TB] FAIL hold_q_frozen_a: got %h expected %h", mem_addr_q, 5'h03); else passed++;
    checks++; if (sel_q !== 1'b0) $display("[TB] FAIL hold_sel_q_frozen: got %b expected %b", sel_q, 1'b0); else passed++;
    checks++; if (addr_chg !== 1'b0) $display("[TB] FAIL hold_chg_a: got %b expected %b", addr_chg, 1'b0); else passed++;
    sel = 1'b0; op_addr = 5'h0C;
    #1;
    checks++; if (mem_addr !== 5'h0C) $display("[TB] FAIL hold_mem_addr_b: got %h expected %h", mem_addr, 5'h0C); else passed++;
    tick();
    checks++; if (mem_addr_q !== 5'h03) $display("[TB] FAIL hold_q_frozen_b: got %h expected %h", mem_addr_q, 5'h03); else passed++;
    checks++; if (addr_chg !== 1'b0) $display("[TB] FAIL hold_chg_b: got %b expected %b", addr_chg, 1'b0); else passed++;
    sel = 1'b1; pc_addr = 5'h15; hold = 1'b0;
    tick();
    checks++; if (mem_addr_q !== 5'h15) $display("[TB] FAIL hold_release_q: got %h expected %h", mem_addr_q, 5'h15); else passed++;
    checks++; if (sel_q !== 1'b1) $display("[TB] FAIL hold_release_sel_q: got %b expected %b", sel_q, 1'b1); else passed++;
    checks++; if (addr_chg !== 1'b1) $display("[TB] FAIL hold_release_chg: got %b expected %b", addr_chg, 1'b1); else passed++;
    tick();
    checks++; if (addr_chg !== 1'b0) $display("[TB] FAIL hold_release_drop: got %b expected %b", addr_chg, 1'b0); else passed++;
  endtask

  task automatic test_async_reset();
    sel = 1'b1; pc_addr = 5'h1F;
    tick();
    checks++; if (mem_addr_q !== 5'h1F) $display("[TB] FAIL arst_pre_q: got %h expected %h", mem_addr_q, 5'h1F); else passed++;
    checks++; if (addr_chg !== 1'b1) $display("[TB] FAIL arst_pre_chg: got %b expected %b", addr_chg, 1'b1); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_addr_q !== 5'h00) $display("[TB] FAIL arst_q: got %h expected %h", mem_addr_q, 5'h00); else passed++;
    checks++; if (sel_q !== 1'b0) $display("[TB] FAIL arst_sel_q: got %b expected %b", sel_q, 1'b0); else passed++;
    checks++; if (addr_chg !== 1'b0) $display("[TB] FAIL arst_chg: got %b expected %b", addr_chg, 1'b0); else passed++;
    checks++; if (mem_addr !== 5'h1F) $display("[TB] FAIL arst_mem_addr: got %h expected %h", mem_addr, 5'h1F); else passed++;
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if (mem_addr_q !== 5'h1F) $display("[TB] FAIL arst_recapture_q: got %h expected %h", mem_addr_q, 5'h1F); else passed++;
    checks++; if (addr_chg !== 1'b1) $display("[TB] FAIL arst_recapture_chg: got %b expected %b", addr_chg, 1'b1); else passed++;
  endtask

  task automatic test_equal_addr();
    sel = 1'b1; pc_addr = 5'h07; op_addr = 5'h07;
    tick();
    tick();
    checks++; if (addr_chg !== 1'b0) $display("[TB] FAIL eq_settled_chg: got %b expected %b", addr_chg, 1'b0); else passed++;
    sel = 1'b0;
    #1;
    checks++; if (mem_addr !== 5'h07) $display("[TB] FAIL eq_mem_addr: got %h expected %h", mem_addr, 5'h07); else passed++;
    tick();
    checks++; if (mem_addr_q !== 5'h07) $display("[TB] FAIL eq_q: got %h expected %h", mem_addr_q, 5'h07); else passed++;
    checks++; if (sel_q !== 1'b0) $display("[TB] FAIL eq_sel_q: got %b expected %b", sel_q, 1'b0); else passed++;
    checks++; if (addr_chg !== 1'b1) $display("[TB] FAIL eq_chg: got %b expected %b", addr_chg, 1'b1); else passed++;
    tick();
    checks++; if (addr_chg !== 1'b0) $display("[TB] FAIL eq_chg_drop: got %b expected %b", addr_chg, 1'b0); else passed++;
  endtask

  task automatic test_zero_after_reset();
    rst_n = 1'b0; sel = 1'b0; op_addr = 5'h00; pc_addr = 5'h1A;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (mem_addr_q !== 5'h00) $display("[TB] FAIL zero_q: got %h expected %h", mem_addr_q, 5'h00); else passed++;
    checks++; if (addr_chg !== 1'b0) $display("[TB] FAIL zero_chg: got %b expected %b", addr_chg, 1'b0); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_op_select();
    test_sel_switch();
    test_full_range();
    test_hold();
    test_async_reset();
    test_equal_addr();
    test_zero_after_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
